pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Sequencer for the fabric PLLs, such as the 24 MHz camera clock PLL. It runs on the PLL reference clock, so it keeps working while the PLL is unlocked. It drives the PLL reset, qualifies the raw lock flag, and releases a clean system reset only after lock has been stable. On loss of lock it re-sequences the PLL, and after repeated lock timeouts it declares a hard failure.

## Interface
Parameters:
- RST_CYCLES, 100: width of the PLL reset pulse, in clkin cycles (≥1)
- LOCK_TIMEOUT, 100000: cycles allowed in WAIT_LOCK before the attempt counts as failed
- LOCK_STABLE, 1024: consecutive synchronized lock-high cycles required before release
- MAX_RETRY, 7: failed lock attempts allowed before FAIL (≥1)

Ports (one clock; reset is asynchronous and active-low):
- clkin  in  1  PLL reference clock; all logic runs on this clock
- reset_n  in  1  asynchronous active-low reset
- lock  in  1  raw PLL lock flag, asynchronous to clkin
- restart  in  1  single-cycle request to re-sequence from any state
- pll_reset  out  1  active-high reset to the PLL
- sys_reset_n  out  1  active-low reset for logic in the PLL output domain
- locked  out  1  high only in RUN
- fail  out  1  high only in FAIL
- relock_cnt  out  8  saturating count of lock losses seen in RUN

## Operation
- lock passes through a 2-flop synchronizer to give lock_s. The supervisor reacts only to lock_s.
- Reset values: pll_reset=1, sys_reset_n=0, locked=0, fail=0, relock_cnt=0, retry=0, state=RESET_PLL.
- All outputs are registered and decoded from the state.
- States:
  - RESET_PLL: pll_reset=1. Stay exactly RST_CYCLES cycles, then go to WAIT_LOCK.
  - WAIT_LOCK: pll_reset=0 and a timeout timer runs.
    - lock_s=1 → STABLE.
    - Timer reaches LOCK_TIMEOUT → retry increments. If retry then equals MAX_RETRY, go to FAIL; otherwise go to RESET_PLL.
  - STABLE: counts consecutive lock_s=1 cycles.
    - lock_s=0 → WAIT_LOCK. The timeout timer restarts from 0; retry does not change.
    - Count reaches LOCK_STABLE → RUN, and retry clears.
  - RUN: sys_reset_n=1 and locked=1.
    - lock_s=0 → RESET_PLL. relock_cnt increments, saturating at 255.
  - FAIL: pll_reset=1, fail=1, sys_reset_n=0. Stays here until restart or reset_n.
- restart has top priority in every state. It forces RESET_PLL and clears retry and all timers; relock_cnt is kept.
- restart and a lock loss in the same cycle act as restart only, so relock_cnt does not increment.
- sys_reset_n is never high unless the state is RUN.

## Timing
- Lock synchronizer latency is 2 cycles.
- After reset_n deasserts, pll_reset stays high for exactly RST_CYCLES clkin edges.
- If lock rises during WAIT_LOCK, sys_reset_n rises 2 + LOCK_STABLE + 1 cycles after the lock edge, within ±1 cycle for synchronizer phase.
- Lock loss in RUN: sys_reset_n and locked fall, and pll_reset rises, 3 cycles after lock falls (2 synchronizer cycles plus 1 registered state update).
- restart takes effect on the next edge. pll_reset=1 in the following cycle.
- Timeout fires on the LOCK_TIMEOUT-th cycle in WAIT_LOCK.
- Asserting reset_n mid-sequence returns every output to its reset value immediately, without waiting for a clock.
- Timer and counter widths are $clog2 of each parameter + 1.
- No combinational path from input to output.

## Configuration
- PLL_SUP_RELOCK_CNT_EN:
  - Defined: the 8-bit saturating relock counter is built as described above.
  - Undefined: relock_cnt is tied to 0 and no counter logic is generated. All other behaviour is identical.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRY=2.
1. Release reset_n, then hold lock=1 from cycle 10 → pll_reset is high for exactly 4 cycles; sys_reset_n=1 and locked=1 appear 11±1 cycles after the lock edge.
2. Drop lock for 1 cycle after 5 cycles in STABLE → return to WAIT_LOCK; release happens only after 8 further consecutive high cycles; no retry is counted.
3. Hold lock=0 throughout → two 20-cycle timeouts, each followed by a 4-cycle pll_reset pulse, then fail=1 with pll_reset=1 held; pulsing restart restarts the sequence with fail=0.
4. Drop lock while in RUN, three times → each drop gives sys_reset_n=0 3 cycles later; relock_cnt=3 when built with PLL_SUP_RELOCK_CNT_EN, and 0 without it.
5. Assert restart in the same cycle as a lock loss in RUN → go to RESET_PLL with relock_cnt unchanged.
6. Assert reset_n in the middle of STABLE and in the middle of RUN → all outputs take their reset values asynchronously, and relock_cnt reads 0.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_supervisor
// Purpose  : Power-up / relock sequencer for a fabric PLL. Runs entirely on
//            the PLL reference clock so it keeps operating while the PLL is
//            unlocked. It pulses the PLL reset, qualifies the raw lock flag,
//            releases a clean system reset after lock has been stable, and
//            re-sequences on lock loss. Repeated lock timeouts end in FAIL.
// Ports    : clkin       - PLL reference clock, the only clock
//            reset_n     - asynchronous active-low reset
//            lock        - raw PLL lock flag, asynchronous to clkin
//            restart     - single-cycle request to re-sequence
//            pll_reset   - active-high reset to the PLL
//            sys_reset_n - active-low reset for the PLL output domain
//            locked      - high only in RUN
//            fail        - high only in FAIL
//            relock_cnt  - saturating count of lock losses seen in RUN
// Options  : PLL_SUP_RELOCK_CNT_EN - when defined, builds the 8-bit relock
//            counter; when undefined, relock_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES   = 100,
  parameter int unsigned LOCK_TIMEOUT = 100000,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned MAX_RETRY    = 7
) (
  input  logic       clkin,
  input  logic       reset_n,
  input  logic       lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       sys_reset_n,
  output logic       locked,
  output logic       fail,
  output logic [7:0] relock_cnt
);

  // --------------------------------------------------------------------------
  // Counter widths and terminal values
  // --------------------------------------------------------------------------
  localparam int unsigned c_RST_W   = $clog2(RST_CYCLES) + 1;
  localparam int unsigned c_TO_W    = $clog2(LOCK_TIMEOUT) + 1;
  localparam int unsigned c_STB_W   = $clog2(LOCK_STABLE) + 1;
  localparam int unsigned c_RETRY_W = $clog2(MAX_RETRY) + 1;

  // Each phase ends on its N-th cycle, i.e. when the count reads N-1.
  localparam logic [c_RST_W-1:0]   c_RST_LAST  = c_RST_W'(RST_CYCLES - 1);
  localparam logic [c_TO_W-1:0]    c_TO_LAST   = c_TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [c_STB_W-1:0]   c_STB_LAST  = c_STB_W'(LOCK_STABLE - 1);
  localparam logic [c_RETRY_W-1:0] c_RETRY_MAX = c_RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic                 r_lock_meta;
  logic                 r_lock_s;

  state_t               r_state;
  state_t               w_next_state;

  logic [c_RST_W-1:0]   r_rst_cnt;
  logic [c_TO_W-1:0]    r_to_cnt;
  logic [c_STB_W-1:0]   r_stb_cnt;
  logic [c_RETRY_W-1:0] r_retry;
  logic [c_RETRY_W-1:0] w_retry_next;

  logic                 r_pll_reset;
  logic                 r_sys_reset_n;
  logic                 r_locked;
  logic                 r_fail;

  // --------------------------------------------------------------------------
  // Lock synchronizer: lock is generated in the PLL domain and is treated as
  // fully asynchronous. Only r_lock_s is used by the sequencer.
  // --------------------------------------------------------------------------
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= lock;
      r_lock_s    <= r_lock_meta;
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_RESET_PLL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and retry logic. restart overrides everything, including a
  // lock loss in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_retry_next = r_retry;
    if (restart) begin
      w_next_state = S_RESET_PLL;
      w_retry_next = '0;
    end else begin
      case (r_state)
        S_RESET_PLL: begin
          if (r_rst_cnt == c_RST_LAST) begin
            w_next_state = S_WAIT_LOCK;
          end
        end
        S_WAIT_LOCK: begin
          // A lock seen on the final timeout cycle still wins.
          if (r_lock_s) begin
            w_next_state = S_STABLE;
          end else if (r_to_cnt == c_TO_LAST) begin
            w_retry_next = r_retry + 1'b1;
            if (w_retry_next == c_RETRY_MAX) begin
              w_next_state = S_FAIL;
            end else begin
              w_next_state = S_RESET_PLL;
            end
          end
        end
        S_STABLE: begin
          // A glitch returns to WAIT_LOCK without costing a retry.
          if (!r_lock_s) begin
            w_next_state = S_WAIT_LOCK;
          end else if (r_stb_cnt == c_STB_LAST) begin
            w_next_state = S_RUN;
            w_retry_next = '0;
          end
        end
        S_RUN: begin
          if (!r_lock_s) begin
            w_next_state = S_RESET_PLL;
          end
        end
        S_FAIL: begin
          w_next_state = S_FAIL;
        end
        default: begin
          w_next_state = S_RESET_PLL;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Phase timers. Each counter is held at zero outside its own state, so it
  // always starts from zero on entry; restart also zeroes them so a restart
  // issued while already in RESET_PLL gives a full-width reset pulse.
  // --------------------------------------------------------------------------
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_cnt <= '0;
      r_to_cnt  <= '0;
      r_stb_cnt <= '0;
      r_retry   <= '0;
    end else begin
      r_retry <= w_retry_next;

      if (restart || (r_state != S_RESET_PLL)) begin
        r_rst_cnt <= '0;
      end else begin
        r_rst_cnt <= r_rst_cnt + 1'b1;
      end

      if (restart || (r_state != S_WAIT_LOCK)) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      if (restart || (r_state != S_STABLE)) begin
        r_stb_cnt <= '0;
      end else begin
        r_stb_cnt <= r_stb_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs, decoded from the next state so they line up with the
  // state register. sys_reset_n can only be high while in RUN.
  // --------------------------------------------------------------------------
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_pll_reset   <= 1'b1;
      r_sys_reset_n <= 1'b0;
      r_locked      <= 1'b0;
      r_fail        <= 1'b0;
    end else begin
      r_pll_reset   <= (w_next_state == S_RESET_PLL) || (w_next_state == S_FAIL);
      r_sys_reset_n <= (w_next_state == S_RUN);
      r_locked      <= (w_next_state == S_RUN);
      r_fail        <= (w_next_state == S_FAIL);
    end
  end

  assign pll_reset   = r_pll_reset;
  assign sys_reset_n = r_sys_reset_n;
  assign locked      = r_locked;
  assign fail        = r_fail;

  // --------------------------------------------------------------------------
  // Relock counter: counts RUN->RESET_PLL transitions caused by lock loss.
  // A restart in the same cycle is not a lock loss.
  // --------------------------------------------------------------------------
`ifdef PLL_SUP_RELOCK_CNT_EN
  logic       w_lock_loss;
  logic [7:0] r_relock_cnt;

  assign w_lock_loss = (r_state == S_RUN) && !r_lock_s && !restart;

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_relock_cnt <= 8'd0;
    end else if (w_lock_loss && (r_relock_cnt != 8'hFF)) begin
      r_relock_cnt <= r_relock_cnt + 8'd1;
    end
  end

  assign relock_cnt = r_relock_cnt;
`else
  assign relock_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_lock_supervisor
// Purpose  : Self-checking bench for pll_lock_supervisor. Expected output
//            values are queued as stimulus is applied and compared when the
//            DUT outputs are sampled, 1 ns after each rising clkin edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_lock_supervisor;

  localparam int unsigned RST_CYCLES   = 4;
  localparam int unsigned LOCK_TIMEOUT = 20;
  localparam int unsigned LOCK_STABLE  = 8;
  localparam int unsigned MAX_RETRY    = 2;

  // Lock edge to RUN: 2 synchronizer cycles + LOCK_STABLE + 1 state update.
  localparam int RELEASE_LAT = 2 + LOCK_STABLE + 1;
  // One RESET_PLL pulse plus one full WAIT_LOCK timeout.
  localparam int ATTEMPT_LEN = RST_CYCLES + LOCK_TIMEOUT;

`ifdef PLL_SUP_RELOCK_CNT_EN
  localparam int RELOCK_EN = 1;
`else
  localparam int RELOCK_EN = 0;
`endif

  localparam int F_PLL_RESET = 0;
  localparam int F_SYS_RST_N = 1;
  localparam int F_LOCKED    = 2;
  localparam int F_FAIL      = 3;
  localparam int F_RELOCK    = 4;

  logic       clkin   = 1'b0;
  logic       reset_n = 1'b0;
  logic       lock    = 1'b0;
  logic       restart = 1'b0;
  logic       pll_reset;
  logic       sys_reset_n;
  logic       locked;
  logic       fail;
  logic [7:0] relock_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] val;
  } exp_t;

  exp_t sb_q[$];

  always #5 clkin = ~clkin;

  pll_lock_supervisor #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .LOCK_STABLE  (LOCK_STABLE),
    .MAX_RETRY    (MAX_RETRY)
  ) u_dut (
    .clkin       (clkin),
    .reset_n     (reset_n),
    .lock        (lock),
    .restart     (restart),
    .pll_reset   (pll_reset),
    .sys_reset_n (sys_reset_n),
    .locked      (locked),
    .fail        (fail),
    .relock_cnt  (relock_cnt)
  );

  // --------------------------------------------------------------------------
  // Checking and scoreboard helpers
  // --------------------------------------------------------------------------
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] field(input int sel);
    case (sel)
      F_PLL_RESET: return {7'd0, pll_reset};
      F_SYS_RST_N: return {7'd0, sys_reset_n};
      F_LOCKED:    return {7'd0, locked};
      F_FAIL:      return {7'd0, fail};
      default:     return relock_cnt;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic push_outs(input string tag, input logic pr, input logic srn,
                           input logic lk, input logic fl);
    push({tag, ".pll_reset"},   F_PLL_RESET, {7'd0, pr});
    push({tag, ".sys_reset_n"}, F_SYS_RST_N, {7'd0, srn});
    push({tag, ".locked"},      F_LOCKED,    {7'd0, lk});
    push({tag, ".fail"},        F_FAIL,      {7'd0, fl});
  endtask

  task automatic push_reset_vals(input string tag);
    push_outs(tag, 1'b1, 1'b0, 1'b0, 1'b0);
    push({tag, ".relock_cnt"}, F_RELOCK, 8'd0);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, field(e.sel), e.val);
    end
  endtask

  // Advance one clkin edge and compare everything queued for this sample.
  task automatic step();
    @(posedge clkin);
    #1;
    drain();
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    lock    = 1'b0;
    restart = 1'b0;
    @(posedge clkin);
    #1;
    push_reset_vals(tag);
    drain();
    reset_n = 1'b1;
  endtask

  task automatic wait_locked(input string tag, input int budget);
    int n;
    n = 0;
    while ((locked !== 1'b1) && (n < budget)) begin
      @(posedge clkin);
      #1;
      n++;
    end
    check(tag, {7'd0, locked}, 8'd1);
  endtask

  // Reset, raise lock after sample 9 and wait for RUN.
  task automatic bring_up(input string tag);
    do_reset({tag, ".rst"});
    for (int s = 1; s <= 9; s++) step();
    lock = 1'b1;
    wait_locked({tag, ".up"}, 40);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    // 1: power-up with lock rising after sample 9.
    do_reset("t1.reset");
    for (int s = 1; s <= 9 + RELEASE_LAT + 2; s++) begin
      push_outs($sformatf("t1.s%0d", s), (s < int'(RST_CYCLES)),
                (s >= 9 + RELEASE_LAT), (s >= 9 + RELEASE_LAT), 1'b0);
      step();
      if (s == 9) lock = 1'b1;
    end

    // 2: one-cycle lock drop after 5 cycles in STABLE (samples 12..16).
    do_reset("t2.reset");
    for (int s = 1; s <= 30; s++) begin
      push_outs($sformatf("t2.s%0d", s), (s < int'(RST_CYCLES)),
                (s >= 16 + 12), (s >= 16 + 12), 1'b0);
      step();
      if (s == 9)  lock = 1'b1;
      if (s == 16) lock = 1'b0;
      if (s == 17) lock = 1'b1;
    end

    // 3: no lock at all -> two timeouts then FAIL; restart recovers.
    do_reset("t3.reset");
    for (int s = 1; s <= MAX_RETRY * ATTEMPT_LEN + 6; s++) begin
      push_outs($sformatf("t3.s%0d", s),
                (s < int'(RST_CYCLES)) ||
                ((s >= ATTEMPT_LEN) && (s < ATTEMPT_LEN + int'(RST_CYCLES))) ||
                (s >= int'(MAX_RETRY) * ATTEMPT_LEN),
                1'b0, 1'b0, (s >= int'(MAX_RETRY) * ATTEMPT_LEN));
      step();
    end
    restart = 1'b1;
    push_outs("t3.restart", 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    restart = 1'b0;
    for (int r = 1; r <= ATTEMPT_LEN + 2; r++) begin
      push_outs($sformatf("t3.r%0d", r),
                (r < int'(RST_CYCLES)) ||
                ((r >= ATTEMPT_LEN) && (r < ATTEMPT_LEN + int'(RST_CYCLES))),
                1'b0, 1'b0, 1'b0);
      step();
    end

    // 4: three lock losses in RUN.
    bring_up("t4");
    for (int k = 1; k <= 3; k++) begin
      lock = 1'b0;
      push_outs($sformatf("t4.k%0d.d1", k), 1'b0, 1'b1, 1'b1, 1'b0);
      step();
      push_outs($sformatf("t4.k%0d.d2", k), 1'b0, 1'b1, 1'b1, 1'b0);
      step();
      push_outs($sformatf("t4.k%0d.d3", k), 1'b1, 1'b0, 1'b0, 1'b0);
      push($sformatf("t4.k%0d.relock_cnt", k), F_RELOCK, 8'(RELOCK_EN * k));
      step();
      lock = 1'b1;
      wait_locked($sformatf("t4.k%0d.relock", k), 60);
    end

    // 5: restart coincident with the lock loss seen in RUN.
    lock = 1'b0;
    push_outs("t5.d1", 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    push_outs("t5.d2", 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    restart = 1'b1;
    push_outs("t5.d3", 1'b1, 1'b0, 1'b0, 1'b0);
    push("t5.relock_cnt", F_RELOCK, 8'(RELOCK_EN * 3));
    step();
    restart = 1'b0;
    for (int r = 1; r <= int'(RST_CYCLES); r++) begin
      push_outs($sformatf("t5.r%0d", r), (r < int'(RST_CYCLES)), 1'b0, 1'b0, 1'b0);
      push($sformatf("t5.r%0d.relock_cnt", r), F_RELOCK, 8'(RELOCK_EN * 3));
      step();
    end

    // 6a: asynchronous reset in the middle of STABLE.
    do_reset("t6a.reset");
    for (int s = 1; s <= 9; s++) step();
    lock = 1'b1;
    for (int s = 10; s <= 16; s++) step();
    push_outs("t6a.pre", 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    #3;
    reset_n = 1'b0;
    #1;
    push_reset_vals("t6a.async");
    drain();

    // 6b: asynchronous reset in the middle of RUN after one relock.
    bring_up("t6b");
    lock = 1'b0;
    for (int s = 1; s <= 3; s++) step();
    lock = 1'b1;
    wait_locked("t6b.relock", 60);
    push("t6b.pre.relock_cnt", F_RELOCK, 8'(RELOCK_EN));
    drain();
    #3;
    reset_n = 1'b0;
    #1;
    push_reset_vals("t6b.async");
    drain();
    reset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
